// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU operation encodings and multiply-sequencer state
//               type used by the execute-stage blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALU operation select, as decoded by the shared combinational ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Multiply sequencer state encodings
  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_RUN    = 3'd1;
  localparam logic [2:0] C_ST_CORR_A = 3'd2;
  localparam logic [2:0] C_ST_CORR_B = 3'd3;
  localparam logic [2:0] C_ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    MUL_IDLE   = C_ST_IDLE,
    MUL_RUN    = C_ST_RUN,
    MUL_CORR_A = C_ST_CORR_A,
    MUL_CORR_B = C_ST_CORR_B,
    MUL_DONE   = C_ST_DONE
  } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_seq.sv
// ============================================================================
// Module      : mul_seq
// Description : Multi-cycle WIDTH x WIDTH -> 2*WIDTH shift-and-add multiply
//               sequencer. Borrows the CPU's shared combinational ALU while
//               busy; the parent muxes the ALU inputs to this block whenever
//               busy is high.
// Options     : MUL_SIGNED_EN - adds the is_signed port and the two-step
//               signed correction (CORR_A / CORR_B states).
// Ports       :
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   launch request, honoured only in IDLE or DONE
//   op_a         in   multiplicand, captured on accepted start
//   op_b         in   multiplier, captured on accepted start
//   is_signed    in   signed multiply select (MUL_SIGNED_EN only)
//   busy         out  high while the block owns the ALU
//   done         out  one-cycle pulse, product valid
//   product_hi   out  upper product word
//   product_lo   out  lower product word
//   prod_zero    out  full product equals zero
//   alu_src_a    out  ALU operand A
//   alu_src_b    out  ALU operand B
//   alu_ctrl     out  ALU operation select
//   alu_result   in   ALU result
//   alu_carry    in   ALU carry-out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MUL_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             prod_zero,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  localparam logic [5:0] C_LAST_STEP = 6'(WIDTH - 1);

  mul_state_t       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [5:0]       r_cnt;
`ifdef MUL_SIGNED_EN
  logic [WIDTH-1:0] r_opb;     // multiplier copy; acc_lo is shifted away
  logic             r_signed;
`endif

  logic w_accept;

  assign w_accept = start && ((r_state == MUL_IDLE) || (r_state == MUL_DONE));

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= MUL_IDLE;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
`ifdef MUL_SIGNED_EN
      r_opb    <= '0;
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        MUL_IDLE, MUL_DONE: begin
          if (w_accept) begin
            r_mcand  <= op_a;
            r_acc_hi <= '0;
            r_acc_lo <= op_b;
            r_cnt    <= '0;
`ifdef MUL_SIGNED_EN
            r_opb    <= op_b;
            r_signed <= is_signed;
`endif
            r_state  <= MUL_RUN;
          end else begin
            r_state  <= MUL_IDLE;
          end
        end

        MUL_RUN: begin
          // The ALU carry becomes the new top bit; the consumed multiplier
          // bit falls off the bottom of acc_lo.
          {r_acc_hi, r_acc_lo} <= {alu_carry, alu_result, r_acc_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == C_LAST_STEP) begin
`ifdef MUL_SIGNED_EN
            r_state <= r_signed ? MUL_CORR_A : MUL_DONE;
`else
            r_state <= MUL_DONE;
`endif
          end
        end

`ifdef MUL_SIGNED_EN
        // Negative multiplicand: remove 2^W * b from the unsigned product
        MUL_CORR_A: begin
          if (r_mcand[WIDTH-1]) begin
            r_acc_hi <= alu_result;
          end
          r_state <= MUL_CORR_B;
        end

        // Negative multiplier: remove 2^W * a from the unsigned product
        MUL_CORR_B: begin
          if (r_opb[WIDTH-1]) begin
            r_acc_hi <= alu_result;
          end
          r_state <= MUL_DONE;
        end
`endif

        default: r_state <= MUL_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ALU operand drive
  // --------------------------------------------------------------------------
  always_comb begin
    alu_src_a = '0;
    alu_src_b = '0;
    alu_ctrl  = ALU_ADD;
    case (r_state)
      MUL_RUN: begin
        alu_src_a = r_acc_hi;
        alu_src_b = r_acc_lo[0] ? r_mcand : '0;
        alu_ctrl  = ALU_ADD;
      end
`ifdef MUL_SIGNED_EN
      MUL_CORR_A: begin
        if (r_mcand[WIDTH-1]) begin
          alu_src_a = r_acc_hi;
          alu_src_b = r_opb;
          alu_ctrl  = ALU_SUB;
        end
      end
      MUL_CORR_B: begin
        if (r_opb[WIDTH-1]) begin
          alu_src_a = r_acc_hi;
          alu_src_b = r_mcand;
          alu_ctrl  = ALU_SUB;
        end
      end
`endif
      default: begin
        alu_src_a = '0;
        alu_src_b = '0;
        alu_ctrl  = ALU_ADD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy       = (r_state == MUL_RUN) || (r_state == MUL_CORR_A) ||
                      (r_state == MUL_CORR_B);
  assign done       = (r_state == MUL_DONE);
  assign product_hi = r_acc_hi;
  assign product_lo = r_acc_lo;
  assign prod_zero  = ~|{r_acc_hi, r_acc_lo};

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
// Module      : tb_mul_seq
// Description : Directed self-checking bench for mul_seq with a behavioural
//               model of the shared ALU wired to the alu_* ports.
// Options     : MUL_SIGNED_EN - also connects is_signed and runs the signed
//               vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic        prod_zero;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;

  int errors = 0;
  int checks = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MUL_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .prod_zero  (prod_zero),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  // Shared ALU model (ADD / SUB / AND / OR)
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_ctrl)
      ALU_ADD: alu_wide = {1'b0, alu_src_a} + {1'b0, alu_src_b};
      ALU_SUB: alu_wide = {1'b0, alu_src_a} - {1'b0, alu_src_b};
      ALU_AND: alu_wide = {1'b0, alu_src_a & alu_src_b};
      default: alu_wide = {1'b0, alu_src_a | alu_src_b};
    endcase
  end
  assign alu_result = alu_wide[31:0];
  assign alu_carry  = alu_wide[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Launch at the next edge; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done (accept cycle+1 = 1).
  // A start pulse with different operands is injected when lat == pulse_at.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = 1;
    while (!done && lat < 60) begin
      if (lat == pulse_at) begin
        op_a  = 32'hDEADBEEF;
        op_b  = 32'h00000003;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
  endtask

  int lat;

  initial begin
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_prod",  {product_hi, product_lo}, 64'd0);
    chk("rst_pzero", {63'd0, prod_zero}, 64'd1);
    chk("rst_alu",   {30'd0, alu_ctrl, alu_src_a}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 3 x 5
    launch(32'd3, 32'd5, 1'b0);
    chk("u35_busy", {63'd0, busy}, 64'd1);
    wait_done(-1, lat);
    chk("u35_lat",   lat, 33);
    chk("u35_prod",  {product_hi, product_lo}, 64'd15);
    chk("u35_pzero", {63'd0, prod_zero}, 64'd0);
    @(posedge clk); #1;
    chk("u35_done_once", {62'd0, busy, done}, 64'd0);
    chk("u35_hold",  {product_hi, product_lo}, 64'd15);

    // All-ones squared: carry on every add
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(-1, lat);
    chk("ff_lat",  lat, 33);
    chk("ff_prod", {product_hi, product_lo}, 64'hFFFFFFFE_00000001);

    // Zero product; a start pulse mid-run must be ignored
    launch(32'd0, 32'h12345678, 1'b0);
    wait_done(10, lat);
    chk("z_lat",   lat, 33);
    chk("z_prod",  {product_hi, product_lo}, 64'd0);
    chk("z_pzero", {63'd0, prod_zero}, 64'd1);
    @(posedge clk); #1;
    chk("z_single_done", {62'd0, busy, done}, 64'd0);

    // Abort by reset during RUN
    launch(32'd9, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_pre", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_state", {62'd0, busy, done}, 64'd0);
    chk("abort_prod",  {product_hi, product_lo}, 64'd0);
    chk("abort_pzero", {63'd0, prod_zero}, 64'd1);
    launch(32'd7, 32'd6, 1'b0);
    wait_done(-1, lat);
    chk("u76_lat",  lat, 33);
    chk("u76_prod", {product_hi, product_lo}, 64'd42);

    // Back-to-back: restart from the done cycle
    launch(32'd2, 32'd2, 1'b0);
    wait_done(-1, lat);
    chk("b2b1_lat",  lat, 33);
    chk("b2b1_prod", {product_hi, product_lo}, 64'd4);
    op_a = 32'd4; op_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_no_gap", {63'd0, busy}, 64'd1);
    wait_done(-1, lat);
    chk("b2b2_lat",  lat, 33);
    chk("b2b2_prod", {product_hi, product_lo}, 64'd16);

`ifdef MUL_SIGNED_EN
    // -1 x 5
    launch(32'hFFFFFFFF, 32'd5, 1'b1);
    wait_done(-1, lat);
    chk("s_m1x5_lat",  lat, 35);
    chk("s_m1x5_prod", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFFB);
    // -3 x -7
    launch(32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1);
    wait_done(-1, lat);
    chk("s_m3xm7_lat",  lat, 35);
    chk("s_m3xm7_prod", {product_hi, product_lo}, 64'd21);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_seq.md
# mul_seq

Multi-cycle 32×32→64 multiply sequencer that drives the CPU's shared combinational ALU with shift-and-add steps. It sits beside the execute stage: a `start` pulse launches a multiply, the block owns the ALU operand/control lines while `busy`, and a one-cycle `done` presents the 64-bit product. The parent wires the ALU and muxes its inputs to this block whenever `busy` is high.

## Interface
- `WIDTH`, 32: operand width. Product is 2×WIDTH.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  launch request; sampled only in IDLE or DONE
- `op_a`  in  32  multiplicand; captured on accepted start
- `op_b`  in  32  multiplier; captured on accepted start
- `is_signed`  in  1  present only with `MUL_SIGNED_EN`; captured on accepted start
- `busy`  out  1  high in RUN/CORR_A/CORR_B
- `done`  out  1  one-cycle pulse; product valid
- `product_hi`  out  32  upper product word
- `product_lo`  out  32  lower product word
- `prod_zero`  out  1  `{product_hi,product_lo}==0`; meaningful when `done`
- `alu_src_a`  out  32  ALU SrcA
- `alu_src_b`  out  32  ALU SrcB
- `alu_ctrl`  out  2  ALU op: 00 ADD, 01 SUB
- `alu_result`  in  32  ALU result
- `alu_carry`  in  1  ALU carry-out

## Operation
- States: IDLE, RUN, CORR_A, CORR_B, DONE. CORR_* exist only with `MUL_SIGNED_EN`.
- Registers: `mcand[31:0]`, `acc_hi[31:0]`, `acc_lo[31:0]` (initially multiplier), `cnt[5:0]`.
- Accepted start (IDLE or DONE, `start=1`): `mcand←op_a`, `acc_hi←0`, `acc_lo←op_b`, `cnt←0`, go to RUN.
- RUN step: `alu_src_a=acc_hi`, `alu_src_b = acc_lo[0] ? mcand : 0`, `alu_ctrl=00`. Next `{acc_hi,acc_lo} ← {alu_carry, alu_result, acc_lo[31:1]}`, `cnt←cnt+1`.
- After the step with `cnt==31`, go to DONE, or to CORR_A when signed.
- CORR_A: if `mcand[31]`, set `alu_src_a=acc_hi`, `alu_src_b=` original `op_b` (latched copy), SUB, and `acc_hi←alu_result`. Otherwise hold. Go to CORR_B.
- CORR_B: if latched `op_b[31]`, set `acc_hi ← acc_hi − mcand` via ALU SUB. Go to DONE.
- DONE: `done=1` for exactly one cycle. Go to RUN if `start`, else IDLE.
- `product_hi/lo` continuously reflect `acc_hi/acc_lo`. Valid while `done` and held stable through IDLE until the next accepted start.
- Outside RUN/CORR: `alu_src_a=0`, `alu_src_b=0`, `alu_ctrl=00`.
- `start` during RUN/CORR is ignored. No queueing.

## Timing
- Reset: state IDLE. `busy=0`, `done=0`, `product_hi=product_lo=0`, `prod_zero=1`, `cnt=0`, `mcand=0`.
- Reset asserted mid-operation aborts at the next edge to the same reset values. No `done` is produced.
- Start accepted at edge k: `busy=1` from cycle k+1 through k+32.
  - Unsigned: `done` in cycle k+33, so latency is 33.
  - Signed: CORR_A in k+33, CORR_B in k+34, `done` in k+35.
- Back-to-back: `start` during the `done` cycle puts RUN in the next cycle, with no IDLE gap.
- The ALU path is combinational in-cycle. Results are registered only at the edge, so there is no extra pipeline stage.

## Configuration
- `MUL_SIGNED_EN` defined:
  - `is_signed` port, CORR_A/CORR_B states and the latched `op_b` copy exist.
  - Signed product = unsigned product − 2^32·(`a<0`?b:0) − 2^32·(`b<0`?a:0), modulo 2^64.
- Undefined: unsigned only. The port, states and copy register are absent. Latency is always 33.

## Structure
- Shared package `alu_pkg`: ALU op encodings (`ALU_ADD=2'b00`, `ALU_SUB=2'b01`, `ALU_AND=2'b10`, `ALU_OR=2'b11`) and the `mul_state_t` enum.
- No sub-module. The ALU is instantiated in the parent, and this block connects only through `alu_*` ports.
- A bench wires the existing ALU to these ports.

## Test plan
- 3 × 5 unsigned → `done` 33 cycles after start. `product_hi=0`, `product_lo=15`, `prod_zero=0`.
- 0xFFFFFFFF × 0xFFFFFFFF unsigned → `product_hi=0xFFFFFFFE`, `product_lo=0x00000001`. Exercises carry on every step.
- 0 × 0x12345678 → product 0, `prod_zero=1`. `start` pulsed at cycle 10 of the op is ignored, with a single `done` at 33.
- Reset at RUN cycle 10 → next cycle IDLE, `busy=0`, product 0. Then 7 × 6 → 42 after 33 cycles.
- Back-to-back: 2×2 then `start` in the `done` cycle with 4×4 → second `done` exactly 33 cycles after the first, with product 16.
- With `MUL_SIGNED_EN`: signed −1 × 5 → `0xFFFFFFFF_FFFFFFFB`. Signed −3 × −7 → 21. Each has `done` at cycle 35.
